// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch over a req/ack handshake into a
// small {pc, inst} FIFO, with redirect flush and a DROP state to retire an abandoned request.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        instWrite,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        instValid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [31:0]        fetch_pc_r;
    logic [31:0]        drop_addr_r, drop_addr_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
    logic [31:0]        pc_mem_r   [DEPTH];
    logic [31:0]        inst_mem_r [DEPTH];

    logic               req_s;
    logic [31:0]        addr_s;
    logic               push_s;
    logic               pop_s;
    logic               has_data_s;
    logic [31:0]        target_pc_s;
    logic               unused_pc_bits_s;

    assign target_pc_s      = {redirectPC[31:2], 2'b00};
    assign unused_pc_bits_s = ^redirectPC[1:0];
    assign has_data_s       = (count_r != {CNT_W{1'b0}});

    // Request generation, DROP bookkeeping and push/pop qualification
    always_comb begin
        state_nxt_s     = state_r;
        drop_addr_nxt_s = drop_addr_r;
        req_s           = 1'b0;
        addr_s          = fetch_pc_r;
        case (state_r)
            ST_RUN: begin
                req_s  = (count_r < DEPTH_C);
                addr_s = fetch_pc_r;
                // An unacked request must still complete at its old address
                if (redirect && req_s && !imemAck) begin
                    state_nxt_s     = ST_DROP;
                    drop_addr_nxt_s = fetch_pc_r;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DROP: begin
                req_s  = 1'b1;
                addr_s = drop_addr_r;
                if (imemAck) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
        push_s = (state_r == ST_RUN) && req_s && imemAck && !redirect;
        pop_s  = instWrite && has_data_s && !redirect;
    end

    // Control state: FSM, fetch address, FIFO pointers and occupancy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_RUN;
            fetch_pc_r  <= RESET_PC;
            drop_addr_r <= RESET_PC;
            count_r     <= {CNT_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drop_addr_r <= drop_addr_nxt_s;
            if (redirect) begin
                fetch_pc_r <= target_pc_s;
                count_r    <= {CNT_W{1'b0}};
                rd_ptr_r   <= {PTR_W{1'b0}};
                wr_ptr_r   <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                    wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care until validated by count_r
    always_ff @(posedge CLK) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
            inst_mem_r[wr_ptr_r] <= imemData;
        end
    end

    assign imemReq   = req_s;
    assign imemAddr  = addr_s;
    assign instValid = has_data_s;
    assign PC        = has_data_s ? pc_mem_r[rd_ptr_r]   : fetch_pc_r;
    assign inst      = has_data_s ? inst_mem_r[rd_ptr_r] : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, slow memory,
// redirect with DROP, redirect on ack+pop, and asynchronous reset mid-DROP.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MASK = 32'hCAFE_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instWrite;
    logic        redirect;
    logic [31:0] redirectPC;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        instValid;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .instWrite  (instWrite),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .PC         (PC),
        .inst       (inst),
        .instValid  (instValid)
    );

    always #5 CLK = ~CLK;

    // Memory returns a word derived from its address so PC and inst differ
    assign imemData = imemAddr ^ MASK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge, in cycle 0 after release
    task automatic do_reset();
        RST        = 1'b1;
        imemAck    = 1'b0;
        instWrite  = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc_e,
                           input logic [31:0] inst_e);
        chk({tag, "_valid"}, {31'd0, instValid}, {31'd0, v});
        chk({tag, "_pc"}, PC, pc_e);
        chk({tag, "_inst"}, inst, inst_e);
    endtask

    initial begin
        // Reset state
        RST = 1'b1; imemAck = 1'b0; instWrite = 1'b0; redirect = 1'b0; redirectPC = 32'h0;
        #12;
        chk_out("rst", 1'b0, 32'h0, NOP);
        chk("rst_addr", imemAddr, 32'h0);

        // Streaming: ack and consume every cycle
        do_reset();
        imemAck = 1'b1; instWrite = 1'b1;
        chk("s0_req", {31'd0, imemReq}, 32'd1);
        chk("s0_addr", imemAddr, 32'h0);
        chk("s0_valid", {31'd0, instValid}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_out("stream", 1'b1, 32'(4 * (k - 1)), 32'(4 * (k - 1)) ^ MASK);
        end

        // Back-pressure: five cycles without consumption
        do_reset();
        imemAck = 1'b1; instWrite = 1'b0;
        tick();
        chk_out("bp1", 1'b1, 32'h0, MASK);
        chk("bp1_addr", imemAddr, 32'h4);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("bp_req_low", {31'd0, imemReq}, 32'd0);
            chk_out("bp_hold", 1'b1, 32'h0, MASK);
        end
        tick();
        instWrite = 1'b1;
        chk_out("bp_rel0", 1'b1, 32'h0, MASK);
        tick();
        chk_out("bp_rel4", 1'b1, 32'h4, 32'h4 ^ MASK);
        chk("bp_rel4_addr", imemAddr, 32'h8);
        tick();
        chk_out("bp_rel8", 1'b1, 32'h8, 32'h8 ^ MASK);

        // Three-cycle memory latency
        do_reset();
        instWrite = 1'b1; imemAck = 1'b0;
        chk("lat_a0", imemAddr, 32'h0);
        tick();
        chk("lat_a1", imemAddr, 32'h0);
        chk("lat_r1", {31'd0, imemReq}, 32'd1);
        tick();
        chk("lat_a2", imemAddr, 32'h0);
        imemAck = 1'b1;
        tick();
        imemAck = 1'b0;
        chk_out("lat_o0", 1'b1, 32'h0, MASK);
        chk("lat_a3", imemAddr, 32'h4);
        tick();
        chk_out("lat_gap", 1'b0, 32'h4, NOP);
        chk("lat_a4", imemAddr, 32'h4);
        tick();
        chk("lat_a5", imemAddr, 32'h4);
        imemAck = 1'b1;
        tick();
        imemAck = 1'b0;
        chk_out("lat_o4", 1'b1, 32'h4, 32'h4 ^ MASK);

        // Redirect to 0x100 while the request for 0x8 is pending
        do_reset();
        imemAck = 1'b1; instWrite = 1'b1;
        tick();
        tick();
        chk_out("rd_pre", 1'b1, 32'h4, 32'h4 ^ MASK);
        imemAck = 1'b0;
        tick();
        chk("rd_pend_addr", imemAddr, 32'h8);
        redirect = 1'b1; redirectPC = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("rd_drop_req", {31'd0, imemReq}, 32'd1);
        chk("rd_drop_addr", imemAddr, 32'h8);
        chk("rd_drop_valid", {31'd0, instValid}, 32'd0);
        tick();
        chk("rd_drop_addr2", imemAddr, 32'h8);
        imemAck = 1'b1;
        tick();
        chk("rd_new_addr", imemAddr, 32'h100);
        chk("rd_new_valid", {31'd0, instValid}, 32'd0);
        tick();
        chk_out("rd_target", 1'b1, 32'h100, 32'h100 ^ MASK);

        // Redirect to 0x202 together with an ack and a pop
        do_reset();
        imemAck = 1'b1; instWrite = 1'b1;
        tick();
        chk_out("rap_pre", 1'b1, 32'h0, MASK);
        redirect = 1'b1; redirectPC = 32'h0000_0202;
        tick();
        redirect = 1'b0;
        chk_out("rap_flush", 1'b0, 32'h200, NOP);
        chk("rap_addr", imemAddr, 32'h200);
        tick();
        chk_out("rap_target", 1'b1, 32'h200, 32'h200 ^ MASK);

        // Asynchronous reset while in DROP
        do_reset();
        imemAck = 1'b1; instWrite = 1'b0;
        tick();
        imemAck = 1'b0;
        redirect = 1'b1; redirectPC = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("ard_drop_addr", imemAddr, 32'h4);
        chk_out("ard_drop", 1'b0, 32'h40, NOP);
        #2;
        RST = 1'b1;
        #1;
        chk_out("ard_rst", 1'b0, 32'h0, NOP);
        chk("ard_rst_addr", imemAddr, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        imemAck = 1'b1; instWrite = 1'b1;
        chk("ard_rel_req", {31'd0, imemReq}, 32'd1);
        chk("ard_rel_addr", imemAddr, 32'h0);
        tick();
        chk_out("ard_first", 1'b1, 32'h0, MASK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the `{PC, inst}` pair consumed by the fetch/decode pipeline register. It issues sequential word fetches to instruction memory over a req/ack handshake, buffers returned words in a small FIFO, and presents them downstream. When the FIFO is empty it presents a NOP. A branch or jump redirect flushes the FIFO and restarts fetching at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `DEPTH`, 2, FIFO entries; power of two, ≥2
- `NOP_INST`, 32'h0000_0013, word presented when empty (`addi x0,x0,0`)

Ports:
- `CLK`  in  1  single clock; all state updates on its rising edge
- `RST`  in  1  asynchronous, active-high reset
- `imemReq`  out  1  fetch request valid
- `imemAddr`  out  32  fetch byte address, word aligned
- `imemAck`  in  1  request accepted and `imemData` valid this cycle
- `imemData`  in  32  returned instruction word
- `instWrite`  in  1  downstream consumes the current output this cycle
- `redirect`  in  1  control-flow redirect strobe
- `redirectPC`  in  32  redirect target; bits [1:0] ignored and forced to 0
- `PC`  out  32  PC of the presented instruction
- `inst`  out  32  presented instruction
- `instValid`  out  1  `inst`/`PC` hold a real fetched instruction

## Operation
- State: `fetchPC` (32), `dropAddr` (32), FIFO of `DEPTH` × {pc, inst}, `count` ($clog2(DEPTH)+1 bits), and FSM {RUN, DROP}.
- One outstanding request at most. A memory transaction completes on any cycle with `imemReq && imemAck`.
- Handshake rule: once `imemReq` is raised, `imemReq` and `imemAddr` stay stable until `imemAck`.

RUN:
- `imemReq = (count < DEPTH)`, `imemAddr = fetchPC`.
- On ack with no redirect: push {fetchPC, imemData}, then `fetchPC += 4`, wrapping mod 2^32.
- Pops cannot make the FIFO overflow. The count check is made when the request is raised, and `count` only falls until the ack.

DROP:
- `imemReq = 1`, `imemAddr = dropAddr`.
- On ack: discard the data and go to RUN.

Output side:
- FIFO non-empty: `PC`/`inst` = head entry, `instValid = 1`.
- FIFO empty: `inst = NOP_INST`, `PC = fetchPC`, `instValid = 0`.
- Pop when `instWrite && count != 0`. `instWrite` while empty has no effect.
- Push and pop in the same cycle leaves `count` unchanged.

Redirect has highest priority, in either state:
- FIFO is flushed (`count <= 0`) and `fetchPC <= {redirectPC[31:2], 2'b00}`.
- Any push and pop that cycle are cancelled, and data acked that cycle is discarded.
- RUN, `imemReq && !imemAck`: latch `dropAddr <= fetchPC` (old address) and go to DROP.
- RUN, otherwise: stay in RUN.
- DROP, without ack: stay in DROP and keep `dropAddr`.
- DROP, with ack: go to RUN.
- Redirect must be acted on every cycle it is asserted, including back-to-back cycles.

## Timing
- Reset (asynchronous, immediate):
  - `fetchPC = RESET_PC`, `count = 0`, state RUN.
  - Outputs: `imemReq = 1` once `RST` deasserts, `imemAddr = RESET_PC`, `instValid = 0`, `inst = NOP_INST`, `PC = RESET_PC`.
- Reset mid-transaction abandons the request. The memory is reset on the same `RST`.
- Latency: an ack in cycle n appears on the outputs in cycle n+1. There is no combinational bypass from `imemData` to `inst`.
- Throughput: with `imemAck` tied high and `instWrite` tied high, one instruction per cycle. The first valid output is the cycle after reset release.
- Redirect asserted in cycle n:
  - `instValid = 0` in cycle n+1.
  - If no drop is pending, the target is requested in cycle n+1 and presented no earlier than n+2.
- All outputs are derived from registered state only, except `imemReq`, which may depend combinationally on `count` in RUN.

## Test plan
- Reset, `imemAck` = 1, `instWrite` = 1, memory word = address:
  - Expect `PC`/`inst` 0x0, 0x4, 0x8, … on consecutive cycles from cycle 1, `instValid = 1` throughout.
- `instWrite` = 0 for 5 cycles, `imemAck` = 1:
  - After 2 pushes `imemReq = 0`, `count = 2`, and output held at PC 0x0.
  - On release, 0x0, 0x4, then 0x8 follow with no gap or duplicate.
- Memory latency 3 cycles (ack on 3rd cycle of request):
  - `imemAddr` is stable for all 3 cycles.
  - One instruction every 3 cycles; `instValid` = 0 between them whenever consumed.
- Redirect to 0x100 while the request for 0x8 is pending (not acked):
  - Enter DROP with `imemAddr = 0x8` held until ack, and that data is discarded.
  - The next request is 0x100, and the next valid output is `PC = 0x100`. No 0x8 reaches the output.
- Redirect to 0x202 on the same cycle as an ack and a pop:
  - FIFO empty next cycle and `fetchPC = 0x200`.
  - The acked word never appears.
- `RST` asserted asynchronously mid-DROP:
  - Outputs return immediately to their reset values.
  - Fetch restarts at `RESET_PC` after release.
